// File: rtl/spi_master_seq_if.sv
// Host-side FIFO handshakes and spi_master strobe bundle for spi_master_seq.
// The sequencer takes the master modport; the host/SPI-master side takes slave.
interface spi_master_seq_if;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       load_master;
   logic [7:0] data_in_master;
   logic       start;
   logic       read_master;
   logic [7:0] data_out_master;
   logic       spi_cs;
   logic       busy;
   logic       err;

   modport master (
      input  tx_valid, tx_data, rx_ready, data_out_master, spi_cs,
      output tx_ready, rx_valid, rx_data, load_master, data_in_master,
             start, read_master, busy, err
   );

   modport slave (
      output tx_valid, tx_data, rx_ready, data_out_master, spi_cs,
      input  tx_ready, rx_valid, rx_data, load_master, data_in_master,
             start, read_master, busy, err
   );
endinterface

// File: rtl/spi_master_seq.sv
// Byte-stream sequencer in front of spi_master: TX FIFO -> load/start/read
// strobes, transfer end detected on spi_cs, received bytes returned via RX FIFO.
module spi_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_ap;
   logic [W-1:0]  head_q, head_d;
   logic          push_ok, pop_ok;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign pop_ok  = pop_i && !empty_o;
   // a pop frees the slot in the same cycle, so push+pop at full keeps the count
   assign push_ok = push_i && (!full_o || pop_ok);
   assign head_o  = head_q;

   // head is registered: compute what the head will be after this edge
   always_comb begin
      rd_d   = rd_q + AW'(pop_ok);
      cnt_ap = cnt_q - CW'(pop_ok);
      cnt_d  = cnt_ap + CW'(push_ok);
      head_d = head_q;
      if (cnt_ap != '0)
         head_d = mem_q[rd_d];
      else if (push_ok)
         head_d = din_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         wr_q   <= wr_q + AW'(push_ok);
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_q] <= din_i;
   end
endmodule

module spi_master_seq #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64
) (
   input logic              mclk,
   input logic              reset,
   spi_master_seq_if.master bus
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, START, WAIT_LO, WAIT_HI, READ, CAPTURE
   } state_e;

   state_e        state_q;
   logic [TW-1:0] timer_q;
   logic          load_q, start_q, read_q, busy_q, err_q;
   logic [7:0]    din_q;
   logic [7:0]    tx_head;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic          timeout;

   assign bus.tx_ready = !tx_full;
   assign bus.rx_valid = !rx_empty;

   spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx (
      .clk     (mclk),
      .rst     (reset),
      .push_i  (bus.tx_valid && !tx_full),
      .din_i   (bus.tx_data),
      .pop_i   (state_q == LOAD),
      .head_o  (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

   spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx (
      .clk     (mclk),
      .rst     (reset),
      .push_i  (state_q == CAPTURE),
      .din_i   (bus.data_out_master),
      .pop_i   (bus.rx_ready),
      .head_o  (bus.rx_data),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );

   assign timeout            = (timer_q == TW'(TIMEOUT - 1));
   assign bus.load_master    = load_q;
   assign bus.start          = start_q;
   assign bus.read_master    = read_q;
   assign bus.data_in_master = din_q;
   assign bus.busy           = busy_q;
   assign bus.err            = err_q;

   // strobes/busy/err are registered: each is set on the edge entering its state
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         load_q  <= 1'b0;
         start_q <= 1'b0;
         read_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         din_q   <= 8'h00;
      end else begin
         load_q  <= 1'b0;
         start_q <= 1'b0;
         read_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               // RX room is reserved here, so the later capture cannot overflow
               if (!tx_empty && !rx_full) begin
                  state_q <= LOAD;
                  load_q  <= 1'b1;
                  din_q   <= tx_head;
                  busy_q  <= 1'b1;
               end
            end
            LOAD: begin
               state_q <= START;
               start_q <= 1'b1;
            end
            START: begin
               state_q <= WAIT_LO;
               timer_q <= '0;
            end
            WAIT_LO: begin
               if (!bus.spi_cs) begin
                  state_q <= WAIT_HI;
                  timer_q <= '0;
               end else if (timeout) begin
                  state_q <= IDLE;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            WAIT_HI: begin
               if (bus.spi_cs) begin
                  state_q <= READ;
                  read_q  <= 1'b1;
               end else if (timeout) begin
                  state_q <= IDLE;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            READ: begin
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_seq.sv
// Randomized bench for spi_master_seq: queue-based TX/RX model, behavioural
// SPI-master/slave responder driving spi_cs, and a host consumer.
module tb_spi_master_seq;
   localparam int DEPTH = 4;

   logic mclk;
   logic reset;

   spi_master_seq_if bif ();

   spi_master_seq #(.FIFO_DEPTH(DEPTH), .TIMEOUT(64)) dut (
      .mclk  (mclk),
      .reset (reset),
      .bus   (bif)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int n_err = 0;

   logic [7:0] txq[$];
   logic [7:0] rxq[$];

   // responder state
   int ph = 0, kind = 0, cnt = 0, t0 = 0, h_cyc = 0, cap_cyc = -1, nload = 0;
   int force_kind = 0, force_resp = -1;
   logic [7:0] last_din = 8'h00;
   logic [7:0] r_resp;

   // host consumer state
   int rx_mode = 0, npop = 0;
   bit pop_once = 1'b0;
   bit rdy;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   always @(posedge mclk) cyc <= cyc + 1;

   always @(negedge mclk) begin
      if (bif.err === 1'b1) n_err <= n_err + 1;
      if ((bif.load_master | bif.start | bif.read_master) === 1'b1)
         chk("strobe_excl", 32'(bif.load_master) + 32'(bif.start) + 32'(bif.read_master), 1);
   end

   // SPI-master/slave model: answers start by dropping then raising cs
   initial begin
      bif.spi_cs = 1'b1;
      bif.data_out_master = 8'h00;
      forever begin
         @(negedge mclk);
         if (reset) begin
            ph = 0;
            bif.spi_cs = 1'b1;
         end else if (bif.load_master) begin
            chk("one_in_flight", 32'(ph), 0);
            last_din = bif.data_in_master;
            if (txq.size() == 0) chk("load_unexpected", 32'(txq.size()), 1);
            else chk("din", 32'(bif.data_in_master), 32'(txq.pop_front()));
            nload++;
            ph = 10;
         end else begin
            case (ph)
               10: begin
                  chk("start_after_load", 32'(bif.start), 1);
                  chk("load_width", 32'(bif.load_master), 0);
                  kind = (force_kind >= 0) ? force_kind
                       : (($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0);
                  cnt = int'($urandom_range(0, 8));
                  t0 = cyc;
                  ph = 1;
               end
               1: begin
                  if (kind == 1) begin
                     if (cyc - t0 == 64) chk("to_lo_early", 32'(bif.err), 0);
                     else if (cyc - t0 == 65) begin
                        chk("to_lo_err", 32'(bif.err), 1);
                        chk("to_lo_idle", 32'(bif.busy), 0);
                        ph = 0;
                     end
                  end else if (cnt == 0) begin
                     bif.spi_cs = 1'b0;
                     cnt = int'($urandom_range(0, 8));
                     t0 = cyc;
                     ph = 2;
                  end else cnt--;
               end
               2: begin
                  if (kind == 2) begin
                     if (cyc - t0 == 64) chk("to_hi_early", 32'(bif.err), 0);
                     else if (cyc - t0 == 65) begin
                        chk("to_hi_err", 32'(bif.err), 1);
                        chk("to_hi_idle", 32'(bif.busy), 0);
                        bif.spi_cs = 1'b1;
                        ph = 0;
                     end
                  end else if (cnt == 0) begin
                     bif.spi_cs = 1'b1;
                     h_cyc = cyc;
                     cap_cyc = cyc + 2;
                     ph = 3;
                  end else cnt--;
               end
               3: begin
                  chk("read_lat", 32'(bif.read_master), 1);
                  r_resp = (force_resp == -2) ? last_din
                         : (force_resp >= 0) ? 8'(force_resp) : 8'($urandom_range(0, 255));
                  bif.data_out_master = r_resp;
                  rxq.push_back(r_resp);
                  ph = 4;
               end
               4: begin
                  chk("capture_busy", 32'(bif.busy), 1);
                  ph = 5;
               end
               5: begin
                  chk("rxv_after_cs", 32'(bif.rx_valid), 1);
                  ph = 0;
               end
               default: ;
            endcase
         end
      end
   end

   // host consumer
   initial begin
      bif.rx_ready = 1'b0;
      forever begin
         @(negedge mclk);
         if (reset) bif.rx_ready = 1'b0;
         else begin
            rdy = (rx_mode == 1) || (rx_mode == 2 && $urandom_range(0, 1) == 1)
                || pop_once || (rx_mode == 3 && cyc == cap_cyc);
            pop_once = 1'b0;
            bif.rx_ready = rdy;
            if (bif.rx_valid && rdy) begin
               if (rxq.size() == 0) chk("rx_unexpected", 32'(rxq.size()), 1);
               else chk("rx_data", 32'(bif.rx_data), 32'(rxq.pop_front()));
               npop++;
            end
         end
      end
   end

   task automatic step();
      @(negedge mclk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      int k;
      k = 0;
      while (!bif.tx_ready && k < 1000) begin
         step();
         k++;
      end
      chk("push_ready", 32'(bif.tx_ready), 1);
      bif.tx_valid = 1'b1;
      bif.tx_data = b;
      txq.push_back(b);
      step();
      bif.tx_valid = 1'b0;
   endtask

   task automatic wait_quiet(input int budget);
      int k;
      k = 0;
      while (!(txq.size() == 0 && rxq.size() == 0 && !bif.busy && ph == 0) && k < budget) begin
         step();
         k++;
      end
      chk("quiet", 32'(k < budget), 1);
   endtask

   task automatic wait_loads(input int target, input int budget);
      int k;
      k = 0;
      while (!(nload == target && ph == 0 && !bif.busy) && k < budget) begin
         step();
         k++;
      end
      chk("loads_done", 32'(nload), 32'(target));
   endtask

   initial begin
      int base, p0, e0, k;
      #900000;
      $display("FAIL watchdog: simulation did not end, checks %0d", n_chk);
      $fatal(1);
   end

   initial begin
      int base, p0, e0, k;
      reset = 1'b0;
      bif.tx_valid = 1'b0;
      bif.tx_data = 8'h00;
      #1 reset = 1'b1;
      step();
      chk("rst_load", 32'(bif.load_master), 0);
      chk("rst_start", 32'(bif.start), 0);
      chk("rst_read", 32'(bif.read_master), 0);
      chk("rst_busy", 32'(bif.busy), 0);
      chk("rst_err", 32'(bif.err), 0);
      chk("rst_din", 32'(bif.data_in_master), 0);
      chk("rst_rxdata", 32'(bif.rx_data), 0);
      chk("rst_rxvalid", 32'(bif.rx_valid), 0);
      chk("rst_txready", 32'(bif.tx_ready), 1);
      reset = 1'b0;
      step();

      // single byte with fixed response and latency checks
      force_kind = 0; force_resp = 8'h3C; rx_mode = 0;
      push(8'hA5);
      chk("load_not_yet", 32'(bif.load_master), 0);
      step();
      chk("load_lat", 32'(bif.load_master), 1);
      chk("load_din", 32'(bif.data_in_master), 32'h A5);
      step();
      chk("start_lat", 32'(bif.start), 1);
      k = 0;
      while (!bif.rx_valid && k < 200) begin step(); k++; end
      chk("rxv_lat", 32'(cyc - h_cyc), 3);
      chk("single_rx", 32'(bif.rx_data), 32'h3C);
      rx_mode = 1;
      wait_quiet(200);

      // burst echo
      force_resp = -2;
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      wait_quiet(400);

      // RX full back-pressure
      force_resp = -1; rx_mode = 0; base = nload;
      for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
      wait_loads(base + 4, 600);
      repeat (5) step();
      chk("bp_busy", 32'(bif.busy), 0);
      chk("bp_loads", 32'(nload - base), 4);
      chk("bp_tx_left", 32'(txq.size()), 1);
      chk("bp_txready", 32'(bif.tx_ready), 1);
      for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
      chk("tx_full", 32'(bif.tx_ready), 0);
      pop_once = 1'b1;
      repeat (12) step();
      chk("bp_fifth", 32'(nload - base), 5);
      rx_mode = 1;
      wait_quiet(1500);

      // timeouts in WAIT_LO and WAIT_HI
      e0 = n_err;
      force_kind = 1;
      push(8'h5A);
      wait_quiet(300);
      force_kind = 2;
      push(8'hC3);
      wait_quiet(300);
      chk("err_count", 32'(n_err - e0), 2);
      chk("to_rx_empty", 32'(bif.rx_valid), 0);

      // reset mid-transfer in WAIT_HI
      force_kind = 0;
      push(8'h77);
      k = 0;
      while (ph != 2 && k < 200) begin step(); k++; end
      chk("reach_wait_hi", 32'(ph), 2);
      @(posedge mclk);
      #2;
      chk("busy_pre_rst", 32'(bif.busy), 1);
      reset = 1'b1;
      #1;
      chk("arst_load", 32'(bif.load_master), 0);
      chk("arst_start", 32'(bif.start), 0);
      chk("arst_read", 32'(bif.read_master), 0);
      chk("arst_busy", 32'(bif.busy), 0);
      chk("arst_txready", 32'(bif.tx_ready), 1);
      chk("arst_rxvalid", 32'(bif.rx_valid), 0);
      chk("arst_din", 32'(bif.data_in_master), 0);
      txq.delete();
      rxq.delete();
      step(); step();
      reset = 1'b0;
      step();
      push(8'h9E);
      wait_quiet(200);

      // simultaneous capture and pop with RX holding two bytes
      rx_mode = 0; base = nload;
      push(8'h11); push(8'h22);
      wait_loads(base + 2, 300);
      chk("simul_pre", 32'(rxq.size()), 2);
      rx_mode = 3; p0 = npop;
      push(8'h33);
      wait_loads(base + 3, 300);
      step();
      chk("simul_pop", 32'(npop - p0), 1);
      rx_mode = 0;
      p0 = npop;
      rx_mode = 1;
      repeat (6) step();
      chk("simul_cnt", 32'(npop - p0), 2);
      wait_quiet(200);

      // randomized traffic with random host drain and occasional timeouts
      force_kind = -1; force_resp = -1; rx_mode = 2;
      for (int i = 0; i < 30; i++) begin
         push(8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 6)) step();
      end
      rx_mode = 1;
      wait_quiet(8000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
